// File: rtl/mem_rsp_decoupler.sv
// rtl/mem_rsp_decoupler.sv - credit-limited decoupler between a ready/valid requester and a fixed-latency memory port
// Responses land in a registered FIFO; credits bound in-flight plus buffered responses to BufDepth.
module mem_rsp_decoupler #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int          RespLat   = 2,
  parameter int unsigned BufDepth  = 4,
  parameter type mem_req_t = struct packed {
    logic q_valid;
    struct packed {
      logic [AddrWidth-1:0]   addr;
      logic                   write;
      logic [DataWidth-1:0]   data;
      logic [DataWidth/8-1:0] strb;
    } q;
  },
  parameter type mem_rsp_t = struct packed {
    logic q_ready;
    struct packed {
      logic                 valid;
      logic [DataWidth-1:0] data;
    } p;
  }
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [AddrWidth-1:0]          req_addr_i,
  input  logic                          req_write_i,
  input  logic [DataWidth-1:0]          req_wdata_i,
  input  logic [DataWidth/8-1:0]        req_strb_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [DataWidth-1:0]          rsp_rdata_o,
  output mem_req_t                      mem_req_o,
  input  mem_rsp_t                      mem_rsp_i,
  output logic [$clog2(BufDepth+1)-1:0] outstanding_o,
  output logic                          err_o
);

  localparam int unsigned CntWidth = $clog2(BufDepth + 1);
  localparam int unsigned PtrWidth = (BufDepth > 1) ? $clog2(BufDepth) : 1;

  if (BufDepth < 1 || RespLat < 0) begin : g_bad_params
    $error("mem_rsp_decoupler: BufDepth must be >= 1 and RespLat >= 0");
  end

  logic [CntWidth-1:0]  cnt_q, fill_q;
  logic [PtrWidth-1:0]  wr_ptr_q, rd_ptr_q;
  logic [DataWidth-1:0] fifo_q [BufDepth];
  logic                 err_q;
  logic                 has_credit, req_hs, rsp_hs, fifo_full, push, drop, cnt_dec;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
    return (ptr == PtrWidth'(BufDepth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign has_credit  = cnt_q < CntWidth'(BufDepth);
  assign req_ready_o = mem_rsp_i.q_ready & has_credit;
  assign req_hs      = req_valid_i & req_ready_o;

  assign rsp_valid_o = (fill_q != '0);
  assign rsp_rdata_o = fifo_q[rd_ptr_q];
  assign rsp_hs      = rsp_valid_o & rsp_ready_i;
  assign fifo_full   = (fill_q == CntWidth'(BufDepth));

  // A pop frees the slot in the same cycle, so a push at full is legal when popping.
  assign push    = mem_rsp_i.p.valid & (cnt_q != '0) & (~fifo_full | rsp_hs);
  assign drop    = mem_rsp_i.p.valid & ~push;
  // Guard keeps the credit counter from wrapping if a stray push left extra entries.
  assign cnt_dec = rsp_hs & (cnt_q != '0);

  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

  always_comb begin
    mem_req_o         = '0;
    mem_req_o.q_valid = req_valid_i & has_credit;
    mem_req_o.q.addr  = req_addr_i;
    mem_req_o.q.write = req_write_i;
    mem_req_o.q.data  = req_wdata_i;
    mem_req_o.q.strb  = req_strb_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      fill_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (req_hs && !cnt_dec) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (!req_hs && cnt_dec) begin
        cnt_q <= cnt_q - 1'b1;
      end

      if (push && !rsp_hs) begin
        fill_q <= fill_q + 1'b1;
      end else if (!push && rsp_hs) begin
        fill_q <= fill_q - 1'b1;
      end

      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (rsp_hs) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (drop) begin
        err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= mem_rsp_i.p.data;
    end
  end

endmodule
